// File: rtl/conv_pkg.sv
// Shared definitions for the convolution scheduler: default image geometry,
// FSM state encoding and a width helper.
package conv_pkg;

  localparam int DEF_IMAGE_WIDTH  = 128;
  localparam int DEF_IMAGE_HEIGHT = 128;
  localparam int DEF_FILTER_SIZE  = 3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LOAD     = 3'd1;
  localparam state_t ST_CONV     = 3'd2;
  localparam state_t ST_WRITE    = 3'd3;
  localparam state_t ST_SHIFT    = 3'd4;
  localparam state_t ST_NEXT_ROW = 3'd5;
  localparam state_t ST_DONE     = 3'd6;

  // Keeps degenerate sizes (n <= 1) at a legal one-bit width.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Output-pixel position tracker: row/column counters plus the linear write
// address, advanced incrementally so no multiplier is needed.
module conv_pos_counter
  import conv_pkg::*;
#(
  parameter int OUT = 126,
  parameter int CW  = cnt_width(OUT),
  parameter int AW  = cnt_width(OUT * OUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          col_inc,
  input  logic          row_inc,
  output logic [CW-1:0] row_count,
  output logic [CW-1:0] col_count,
  output logic [AW-1:0] wr_addr
);

  localparam logic [CW-1:0] LAST = CW'(OUT - 1);

  logic [CW-1:0] row_q, col_q;
  logic [AW-1:0] addr_q;

  // Moving to the next row from column OUT-1 lands on (row+1)*OUT, which is
  // exactly one past the previous address, so both moves add one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else if (clear) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else if (row_inc && (row_q < LAST)) begin
      row_q  <= row_q + 1'b1;
      col_q  <= '0;
      addr_q <= addr_q + 1'b1;
    end else if (col_inc && (col_q < LAST)) begin
      col_q  <= col_q + 1'b1;
      addr_q <= addr_q + 1'b1;
    end
  end

  assign row_count = row_q;
  assign col_count = col_q;
  assign wr_addr   = addr_q;

endmodule

// File: rtl/conv_scheduler.sv
// Frame sequencer for a sliding-window convolution datapath: walks every
// output pixel through load / convolve / write / shift handshakes.
module conv_scheduler
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int FILTER_SIZE  = DEF_FILTER_SIZE,
  parameter int OUT          = IMAGE_HEIGHT - FILTER_SIZE + 1,
  localparam int CW          = cnt_width(OUT),
  localparam int AW          = cnt_width(OUT * OUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          loaded,
  input  logic          window_valid,
  input  logic          result_valid,
  output logic          load_en,
  output logic          shift_en,
  output logic          conv_en,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [CW-1:0] row_count,
  output logic [CW-1:0] col_count,
  output logic [2:0]    state,
  output logic          busy,
  output logic          done
);

  if (IMAGE_WIDTH != IMAGE_HEIGHT) begin : g_bad_dims
    $error("conv_scheduler supports square images only");
  end

  localparam logic [CW-1:0] LAST = CW'(OUT - 1);

  state_t state_q, state_d;
  logic   clear, col_inc, row_inc;

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    col_inc = 1'b0;
    row_inc = 1'b0;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      clear   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_d = ST_LOAD;
            clear   = 1'b1;
          end
        end
        ST_LOAD:  if (loaded)       state_d = ST_CONV;
        ST_CONV:  if (result_valid) state_d = ST_WRITE;
        ST_WRITE: begin
          if (col_count < LAST)      state_d = ST_SHIFT;
          else if (row_count < LAST) state_d = ST_NEXT_ROW;
          else                       state_d = ST_DONE;
        end
        ST_SHIFT: begin
          if (window_valid) begin
            state_d = ST_CONV;
            col_inc = 1'b1;
          end
        end
        ST_NEXT_ROW: begin
          state_d = ST_LOAD;
          row_inc = 1'b1;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      load_en  <= 1'b0;
      conv_en  <= 1'b0;
      wr_en    <= 1'b0;
      shift_en <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      load_en  <= (state_d == ST_LOAD);
      conv_en  <= (state_d == ST_CONV);
      wr_en    <= (state_d == ST_WRITE);
      shift_en <= (state_d == ST_SHIFT);
      done     <= (state_d == ST_DONE);
      busy     <= (state_d != ST_IDLE);
    end
  end

  assign state = state_q;

  conv_pos_counter #(
    .OUT (OUT),
    .CW  (CW),
    .AW  (AW)
  ) u_pos (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .col_inc   (col_inc),
    .row_inc   (row_inc),
    .row_count (row_count),
    .col_count (col_count),
    .wr_addr   (wr_addr)
  );

endmodule
